// File: rtl/c1_write_arbiter.sv
// c1_write_arbiter: merges NUM_REQ CCI-P channel-1 write streams onto one port.
//   clk, reset           : rising-edge clock, synchronous active-high reset
//   c1TxAlmFull          : shell back-pressure; blocks grants while high
//   af2cp_sTx_c1         : merged, registered write request toward the shell
//   cp2af_sRx_c1         : write responses from the shell
//   req_sTx_c1[i]        : requester i write requests (captured into a skid FIFO)
//   req_c1TxAlmFull[i]   : registered back-pressure to requester i
//   req_sRx_c1[i]        : responses routed to requester i by mdata[1:0]
//   req_idle[i]          : FIFO empty, nothing in flight, nothing in output register
//   req_outstanding[i]   : issued but not yet acknowledged writes (saturating)
package ccip_if_pkg;
  typedef struct packed {
    logic [3:0]  req_type;
    logic [41:0] address;
    logic [15:0] mdata;
  } t_ccip_c1_ReqMemHdr;

  typedef struct packed {
    logic [3:0]  resp_type;
    logic [15:0] mdata;
  } t_ccip_c1_RspMemHdr;

  typedef struct packed {
    t_ccip_c1_ReqMemHdr hdr;
    logic [511:0]       data;
    logic               valid;
  } t_if_ccip_c1_Tx;

  typedef struct packed {
    t_ccip_c1_RspMemHdr hdr;
    logic               rspValid;
  } t_if_ccip_c1_Rx;
endpackage

module c1_write_arbiter
  import ccip_if_pkg::*;
#(
  parameter int NUM_REQ        = 4,
  parameter int FIFO_DEPTH     = 8,
  parameter int ALMFULL_THRESH = 4
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           c1TxAlmFull,
  output t_if_ccip_c1_Tx af2cp_sTx_c1,
  input  t_if_ccip_c1_Rx cp2af_sRx_c1,
  input  t_if_ccip_c1_Tx req_sTx_c1      [NUM_REQ],
  output logic           req_c1TxAlmFull [NUM_REQ],
  output t_if_ccip_c1_Rx req_sRx_c1      [NUM_REQ],
  output logic           req_idle        [NUM_REQ],
  output logic [15:0]    req_outstanding [NUM_REQ]
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] AF_CNT   = CNT_W'(ALMFULL_THRESH);

  typedef struct packed {
    t_ccip_c1_ReqMemHdr hdr;
    logic [511:0]       data;
  } t_entry;

  t_entry             mem     [NUM_REQ][FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr  [NUM_REQ];
  logic [PTR_W-1:0]   rd_ptr  [NUM_REQ];
  logic [CNT_W-1:0]   cnt     [NUM_REQ];
  logic [CNT_W-1:0]   cnt_nxt [NUM_REQ];
  logic [15:0]        outst_nxt [NUM_REQ];
  logic [NUM_REQ-1:0] push_ok, pop, empty, rsp_hit, issue_hit;
  logic [NUM_REQ-1:0] overflow;
  logic [1:0]         rr_ptr, cand;

  logic               gnt_vld_p0;
  logic [1:0]         gnt_idx_p0;
  t_entry             head_p0;
  t_ccip_c1_ReqMemHdr issue_hdr_p0;

  logic               out_vld_p1;
  logic [1:0]         out_idx_p1;
  t_ccip_c1_ReqMemHdr out_hdr_p1;
  logic [511:0]       out_data_p1;
  logic [NUM_REQ-1:0] rsp_vld_p1;
  t_ccip_c1_RspMemHdr rsp_hdr_p1;

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      empty[i]   = (cnt[i] == '0);
      // A push into a full FIFO is dropped even if that FIFO pops this cycle.
      push_ok[i] = req_sTx_c1[i].valid && (cnt[i] != FULL_CNT);
    end
  end

  // ---- Stage p0: round-robin grant and FIFO head read ----
  always_comb begin
    gnt_vld_p0 = 1'b0;
    gnt_idx_p0 = '0;
    cand       = '0;
    if (!c1TxAlmFull) begin
      for (int k = 0; k < NUM_REQ; k++) begin
        cand = 2'((int'(rr_ptr) + k) % NUM_REQ);
        if (!gnt_vld_p0 && !empty[cand]) begin
          gnt_vld_p0 = 1'b1;
          gnt_idx_p0 = cand;
        end
      end
    end
    head_p0                 = mem[gnt_idx_p0][rd_ptr[gnt_idx_p0]];
    issue_hdr_p0            = head_p0.hdr;
    issue_hdr_p0.mdata[1:0] = gnt_idx_p0;
  end

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      pop[i]       = gnt_vld_p0 && (gnt_idx_p0 == 2'(i));
      cnt_nxt[i]   = cnt[i] + CNT_W'(push_ok[i]) - CNT_W'(pop[i]);
      rsp_hit[i]   = cp2af_sRx_c1.rspValid && (cp2af_sRx_c1.hdr.mdata[1:0] == 2'(i));
      issue_hit[i] = out_vld_p1 && (out_idx_p1 == 2'(i));
      outst_nxt[i] = req_outstanding[i];
      if (issue_hit[i] && !rsp_hit[i] && (req_outstanding[i] != 16'hFFFF))
        outst_nxt[i] = req_outstanding[i] + 16'd1;
      else if (rsp_hit[i] && !issue_hit[i] && (req_outstanding[i] != 16'h0000))
        outst_nxt[i] = req_outstanding[i] - 16'd1;
    end
  end

  // FIFO storage is data only and is never reset.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_REQ; i++) begin
      if (push_ok[i])
        mem[i][wr_ptr[i]] <= '{hdr: req_sTx_c1[i].hdr, data: req_sTx_c1[i].data};
    end
  end

  // ---- Stage p1: output register, response routing, per-requester state ----
  always_ff @(posedge clk) begin
    if (gnt_vld_p0) begin
      out_hdr_p1  <= issue_hdr_p0;
      out_data_p1 <= head_p0.data;
    end
    rsp_hdr_p1 <= cp2af_sRx_c1.hdr;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr     <= '0;
      out_vld_p1 <= 1'b0;
      out_idx_p1 <= '0;
      rsp_vld_p1 <= '0;
      overflow   <= '0;
      for (int i = 0; i < NUM_REQ; i++) begin
        wr_ptr[i]          <= '0;
        rd_ptr[i]          <= '0;
        cnt[i]             <= '0;
        req_c1TxAlmFull[i] <= 1'b0;
        req_outstanding[i] <= '0;
        req_idle[i]        <= 1'b1;
      end
    end else begin
      out_vld_p1 <= gnt_vld_p0;
      rsp_vld_p1 <= rsp_hit;
      if (gnt_vld_p0) begin
        out_idx_p1 <= gnt_idx_p0;
        rr_ptr     <= 2'((int'(gnt_idx_p0) + 1) % NUM_REQ);
      end
      for (int i = 0; i < NUM_REQ; i++) begin
        if (push_ok[i]) wr_ptr[i] <= wr_ptr[i] + 1'b1;
        if (pop[i])     rd_ptr[i] <= rd_ptr[i] + 1'b1;
        if (req_sTx_c1[i].valid && !push_ok[i]) overflow[i] <= 1'b1;
        cnt[i]             <= cnt_nxt[i];
        req_c1TxAlmFull[i] <= (cnt_nxt[i] >= AF_CNT) || c1TxAlmFull;
        req_outstanding[i] <= outst_nxt[i];
        // A popped entry sits in the output register next cycle and is not
        // yet counted as outstanding, so it must hold idle low on its own.
        req_idle[i]        <= (cnt_nxt[i] == '0) && (outst_nxt[i] == '0) && !pop[i];
      end
    end
  end

  always_comb begin
    af2cp_sTx_c1 = '{hdr: out_hdr_p1, data: out_data_p1, valid: out_vld_p1};
    for (int i = 0; i < NUM_REQ; i++)
      req_sRx_c1[i] = '{hdr: rsp_hdr_p1, rspValid: rsp_vld_p1[i]};
  end

  // Overflow flags are sticky until reset.
  assert property (@(posedge clk) disable iff (reset) (($past(overflow) & ~overflow) == '0));

endmodule

// File: tb/tb_c1_write_arbiter.sv
// Directed bench for c1_write_arbiter: single stream, round-robin order,
// shell back-pressure, same-cycle issue/response, mid-run reset, overflow.
module tb_c1_write_arbiter;
  import ccip_if_pkg::*;

  localparam logic [15:0] MD = 16'hA5A7;

  logic           clk;
  logic           reset;
  logic           c1alm;
  t_if_ccip_c1_Tx af_tx;
  t_if_ccip_c1_Rx rx_in;
  t_if_ccip_c1_Tx req_tx  [4];
  logic           alm     [4];
  t_if_ccip_c1_Rx rsp_out [4];
  logic           idle    [4];
  logic [15:0]    outst   [4];

  int ncheck = 0;
  int nerr   = 0;

  c1_write_arbiter #(.NUM_REQ(4), .FIFO_DEPTH(8), .ALMFULL_THRESH(4)) dut (
    .clk             (clk),
    .reset           (reset),
    .c1TxAlmFull     (c1alm),
    .af2cp_sTx_c1    (af_tx),
    .cp2af_sRx_c1    (rx_in),
    .req_sTx_c1      (req_tx),
    .req_c1TxAlmFull (alm),
    .req_sRx_c1      (rsp_out),
    .req_idle        (idle),
    .req_outstanding (outst)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    ncheck++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clr();
    for (int i = 0; i < 4; i++) req_tx[i].valid = 1'b0;
    rx_in.rspValid = 1'b0;
  endtask

  task automatic push(input int i, input logic [41:0] a);
    req_tx[i].valid          = 1'b1;
    req_tx[i].hdr.req_type   = 4'h1;
    req_tx[i].hdr.address    = a;
    req_tx[i].hdr.mdata      = MD;
    req_tx[i].data           = {8{64'(a)}};
  endtask

  task automatic rsp(input logic [1:0] idx);
    rx_in.rspValid      = 1'b1;
    rx_in.hdr.resp_type = 4'h1;
    rx_in.hdr.mdata     = {14'h1234, idx};
  endtask

  task automatic chk_out(input string tag, input logic [1:0] idx, input logic [41:0] a);
    chk({tag, "_vld"}, 64'(af_tx.valid), 64'd1);
    chk({tag, "_adr"}, 64'(af_tx.hdr.address), 64'(a));
    chk({tag, "_md"},  64'(af_tx.hdr.mdata), 64'((MD & 16'hFFFC) | {14'b0, idx}));
    chk({tag, "_dat"}, af_tx.data[63:0], 64'(a));
  endtask

  task automatic do_reset();
    clr();
    c1alm = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  initial begin
    int seen;
    for (int i = 0; i < 4; i++) req_tx[i] = '0;
    rx_in = '0;
    c1alm = 1'b0;
    reset = 1'b1;
    tick();
    tick();
    // Reset state
    chk("rst_vld", 64'(af_tx.valid), 64'd0);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("rst_outst%0d", i), 64'(outst[i]), 64'd0);
      chk($sformatf("rst_idle%0d", i), 64'(idle[i]), 64'd1);
      chk($sformatf("rst_alm%0d", i), 64'(alm[i]), 64'd0);
      chk($sformatf("rst_rsp%0d", i), 64'(rsp_out[i].rspValid), 64'd0);
    end
    reset = 1'b0;

    // Single requester, three consecutive lines
    clr(); push(0, 42'h100); tick();
    chk("t1_lat", 64'(af_tx.valid), 64'd0);
    clr(); push(0, 42'h101); tick();
    chk_out("t1_w0", 2'd0, 42'h100);
    clr(); push(0, 42'h102); tick();
    chk_out("t1_w1", 2'd0, 42'h101);
    clr(); tick();
    chk_out("t1_w2", 2'd0, 42'h102);
    chk("t1_idle_busy", 64'(idle[0]), 64'd0);
    clr(); tick();
    chk("t1_vld_off", 64'(af_tx.valid), 64'd0);
    chk("t1_outst3", 64'(outst[0]), 64'd3);
    rsp(2'd0); tick();
    chk("t1_rsp0", 64'(rsp_out[0].rspValid), 64'd1);
    chk("t1_rsp1", 64'(rsp_out[1].rspValid), 64'd0);
    chk("t1_outst2", 64'(outst[0]), 64'd2);
    rsp(2'd0); tick();
    chk("t1_outst1", 64'(outst[0]), 64'd1);
    rsp(2'd0); tick();
    chk("t1_outst0", 64'(outst[0]), 64'd0);
    chk("t1_idle", 64'(idle[0]), 64'd1);
    clr(); tick();
    chk("t1_rsp_off", 64'(rsp_out[0].rspValid), 64'd0);

    // All four requesters at once, then 0 and 2 alternating
    do_reset();
    clr();
    for (int i = 0; i < 4; i++) push(i, 42'h200 + 42'(i));
    tick();
    clr(); tick();
    chk_out("t2_g0", 2'd0, 42'h200);
    tick();
    chk_out("t2_g1", 2'd1, 42'h201);
    tick();
    chk_out("t2_g2", 2'd2, 42'h202);
    tick();
    chk_out("t2_g3", 2'd3, 42'h203);
    clr(); push(0, 42'h300); push(2, 42'h310); tick();
    chk("t2_gap", 64'(af_tx.valid), 64'd0);
    clr(); push(0, 42'h301); push(2, 42'h311); tick();
    chk_out("t2_r0", 2'd0, 42'h300);
    clr(); tick();
    chk_out("t2_r2", 2'd2, 42'h310);
    tick();
    chk_out("t2_r0b", 2'd0, 42'h301);
    tick();
    chk_out("t2_r2b", 2'd2, 42'h311);
    tick();
    chk("t2_end", 64'(af_tx.valid), 64'd0);

    // Shell back-pressure while requester 1 queues four lines
    do_reset();
    c1alm = 1'b1;
    for (int k = 0; k < 10; k++) begin
      clr();
      if (k < 4) push(1, 42'h400 + 42'(k));
      tick();
      chk($sformatf("t3_hold%0d", k), 64'(af_tx.valid), 64'd0);
    end
    chk("t3_alm1", 64'(alm[1]), 64'd1);
    chk("t3_alm0", 64'(alm[0]), 64'd1);
    clr();
    c1alm = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk_out($sformatf("t3_w%0d", k), 2'd1, 42'h400 + 42'(k));
      if (k == 0) chk("t3_alm1_rel", 64'(alm[1]), 64'd0);
    end
    tick();
    chk("t3_end", 64'(af_tx.valid), 64'd0);

    // Response for requester 2 in the same cycle as an issue for it
    do_reset();
    clr(); push(2, 42'h500); tick();
    clr(); push(2, 42'h501); tick();
    chk_out("t4_w0", 2'd2, 42'h500);
    clr(); tick();
    chk_out("t4_w1", 2'd2, 42'h501);
    chk("t4_outst_pre", 64'(outst[2]), 64'd1);
    rsp(2'd2); tick();
    chk("t4_outst_same", 64'(outst[2]), 64'd1);
    chk("t4_rsp2", 64'(rsp_out[2].rspValid), 64'd1);
    chk("t4_rsp0", 64'(rsp_out[0].rspValid), 64'd0);
    chk("t4_rsp1", 64'(rsp_out[1].rspValid), 64'd0);
    chk("t4_rsp3", 64'(rsp_out[3].rspValid), 64'd0);
    clr(); tick();
    chk("t4_rsp2_off", 64'(rsp_out[2].rspValid), 64'd0);
    chk("t4_outst_post", 64'(outst[2]), 64'd1);

    // Mid-run reset with lines queued and writes outstanding
    do_reset();
    clr(); push(0, 42'h600); tick();
    clr(); push(0, 42'h601); tick();
    clr(); push(0, 42'h602); tick();
    clr(); tick();
    tick();
    chk("t5_outst3", 64'(outst[0]), 64'd3);
    c1alm = 1'b1;
    for (int k = 0; k < 5; k++) begin
      clr(); push(1, 42'h700 + 42'(k)); tick();
    end
    clr();
    chk("t5_alm1", 64'(alm[1]), 64'd1);
    reset = 1'b1;
    tick();
    chk("t5_vld", 64'(af_tx.valid), 64'd0);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("t5_outst%0d", i), 64'(outst[i]), 64'd0);
      chk($sformatf("t5_idle%0d", i), 64'(idle[i]), 64'd1);
    end
    reset = 1'b0;
    c1alm = 1'b0;
    seen = 0;
    for (int k = 0; k < 10; k++) begin
      tick();
      if (af_tx.valid) seen++;
    end
    chk("t5_noissue", 64'(seen), 64'd0);
    chk("t5_idle1", 64'(idle[1]), 64'd1);
    rsp(2'd0); tick();
    chk("t5_late_rsp", 64'(rsp_out[0].rspValid), 64'd1);
    chk("t5_no_under", 64'(outst[0]), 64'd0);
    clr();

    // Push into a full FIFO
    do_reset();
    c1alm = 1'b1;
    for (int k = 0; k < 9; k++) begin
      clr(); push(3, 42'h800 + 42'(k)); tick();
      if (k == 7) chk("t6_ovf_before", 64'(dut.overflow[3]), 64'd0);
    end
    chk("t6_ovf3", 64'(dut.overflow[3]), 64'd1);
    chk("t6_ovf0", 64'(dut.overflow[0]), 64'd0);
    clr();
    c1alm = 1'b0;
    for (int k = 0; k < 8; k++) begin
      tick();
      chk_out($sformatf("t6_w%0d", k), 2'd3, 42'h800 + 42'(k));
    end
    tick();
    chk("t6_dropped", 64'(af_tx.valid), 64'd0);

    $display("CHECKS %0d ERRORS %0d", ncheck, nerr);
    $finish;
  end
endmodule

// File: doc/c1_write_arbiter.md
C1_WRITE_ARBITER -- requirements
Module: c1_write_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4, number of write requesters; legal range 1..4.
REQ-002 Parameter FIFO_DEPTH, default 8, per-requester skid FIFO depth in CCI-P lines; power of two.
REQ-003 Parameter ALMFULL_THRESH, default 4, occupancy at which a requester's almost-full asserts.
REQ-004 Port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-005 Port reset, input, 1 bit: synchronous, active-high reset.
REQ-006 Port c1TxAlmFull, input, 1 bit: shell back-pressure on CCI-P channel 1.
REQ-007 Port af2cp_sTx_c1, output, t_if_ccip_c1_Tx: merged write request toward the shell.
REQ-008 Port cp2af_sRx_c1, input, t_if_ccip_c1_Rx: write responses from the shell.
REQ-009 Port req_sTx_c1[NUM_REQ], input, t_if_ccip_c1_Tx: per-requester write requests.
REQ-010 Port req_c1TxAlmFull[NUM_REQ], output, 1 bit each: per-requester back-pressure.
REQ-011 Port req_sRx_c1[NUM_REQ], output, t_if_ccip_c1_Rx: per-requester routed write responses.
REQ-012 Port req_idle[NUM_REQ], output, 1 bit each: FIFO empty and no outstanding writes.
REQ-013 Port req_outstanding[NUM_REQ], output, 16 bits each: issued but not yet acknowledged writes.

Function
REQ-014 Each requester has a FIFO that captures hdr and data of every cycle with req_sTx_c1[i].valid=1, in the same cycle.
REQ-015 req_c1TxAlmFull[i] shall be registered and equal (occupancy_i >= ALMFULL_THRESH) OR c1TxAlmFull.
REQ-016 Requesters stop within FIFO_DEPTH-ALMFULL_THRESH cycles of almost-full. A push into a full FIFO is dropped and sets a sticky per-requester overflow flag, which is visible in simulation assertions.
REQ-017 Arbitration is round-robin over non-empty FIFOs, starting at the index after the last granted one. After reset, the search starts at index 0.
REQ-018 At most one grant per cycle, and no grant in a cycle where c1TxAlmFull=1.
REQ-019 A granted entry is popped, and af2cp_sTx_c1 is registered with valid=1 one cycle after the grant. Otherwise af2cp_sTx_c1.valid=0, and hdr and data hold their last values.
REQ-020 On issue, hdr.mdata[1:0] is overwritten with the requester index; all other hdr fields and data pass through unchanged.
REQ-021 Responses are routed on cp2af_sRx_c1.rspValid=1. The response goes to the requester given by hdr.mdata[1:0], one cycle later, with rspValid=1 only for that requester. A response with index >= NUM_REQ is discarded.
REQ-022 Requesters shall not depend on response mdata[1:0].
REQ-023 req_outstanding[i] increments on issue and decrements on routed response. On simultaneous issue and response for the same i it is unchanged.
REQ-024 req_outstanding[i] saturates at 0xFFFF and does not underflow below 0.
REQ-025 req_idle[i] = FIFO_i empty AND req_outstanding[i]==0 AND no write for i is in the output register; it is registered.
REQ-026 A push and a pop on the same FIFO in the same cycle leave the occupancy unchanged; a push into an empty FIFO is poppable on the next cycle, not the same one.
REQ-027 Each FIFO's read and write pointers wrap modulo FIFO_DEPTH.
REQ-028 The arbiter has no op_start, no op_done and no configuration; it is always active.

Reset
REQ-029 While reset=1: FIFOs are emptied, af2cp_sTx_c1.valid=0, all req_sRx_c1 rspValid=0, req_outstanding=0, req_idle=1, req_c1TxAlmFull=0, the round-robin pointer is set to 0, and the overflow flags are cleared.
REQ-030 Reset mid-operation discards queued writes and in-flight counts. Responses arriving after reset are routed, but they do not decrement a count below 0.

Verification
REQ-031 Single requester 0 pushes 3 lines, addresses A, A+1, A+2 -> three valid requests on consecutive cycles in order, mdata[1:0]=0, first one 2 cycles after the first push. 3 responses -> req_outstanding[0] goes 3 to 0 and req_idle[0]=1.
REQ-032 All 4 requesters push 1 line in the same cycle -> issue order is 0,1,2,3. Next round, with requesters 0 and 2 active and last grant 3 -> order is 0,2,0,2.
REQ-033 c1TxAlmFull=1 for 10 cycles while requester 1 pushes 4 lines -> no valid output; req_c1TxAlmFull[1]=1; after release, 4 writes issue back-to-back.
REQ-034 Response with mdata[1:0]=2 in the same cycle as an issue for requester 2 -> req_outstanding[2] unchanged; only req_sRx_c1[2].rspValid pulses.
REQ-035 Reset asserted with 5 lines queued and 3 outstanding -> next cycle: valid=0, all outstanding=0, all idle=1; no queued line is issued afterwards.
REQ-036 Push into a full FIFO (8 entries, c1TxAlmFull held at 1) -> the line is dropped, the overflow flag is set, and the first 8 lines issue intact.
